dec_compare_checker: RTL and testbench
======================================

Name: dec_compare_checker

Overview:
- Pipelined, multi-channel successor to dec_comparator.
- Compares NUM_CH decoded words (A) against expected words (B) under a shared bit mask.
- Reports, per beat: per-channel equality and per-channel bit-error counts.
- Accumulates statistics across beats: saturating mismatch-beat counter, plus capture of the first mismatching channel.
- Sits at the decoder output in loopback/self-test paths, replacing ad-hoc bench-side equality checks.

Parameters:
- DATA_DEPTH, 32, width of one channel word in bits.
- NUM_CH, 4, number of parallel channels (≥1).
- CNT_WIDTH, 16, width of the mismatch-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear of accumulators (errCnt, firstErr*, sticky); pipeline unaffected.
- in_valid  in  1  A/B/mask valid this cycle.
- A  in  NUM_CH*DATA_DEPTH  decoded words; channel c at bits [c*DATA_DEPTH +: DATA_DEPTH].
- B  in  NUM_CH*DATA_DEPTH  expected words; same packing.
- mask  in  DATA_DEPTH  1 = bit compared, 0 = ignored; applies to all channels.
- out_valid  out  1  results valid.
- isEqual  out  NUM_CH  per-channel masked equality.
- allEqual  out  1  AND of isEqual.
- bitErr  out  NUM_CH*EW  per-channel masked differing-bit count, EW = $clog2(DATA_DEPTH+1).
- errCnt  out  CNT_WIDTH  number of valid beats with allEqual=0, saturating.
- firstErrValid  out  1  a first mismatch has been captured.
- firstErrCh  out  max(1,$clog2(NUM_CH))  lowest mismatching channel index of the first mismatching beat.
- sticky  out  1  set on any mismatch beat; held until clr or reset.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs and internal registers go to 0. This includes out_valid, isEqual, allEqual, bitErr, errCnt, firstErrValid, firstErrCh and sticky. Any in-flight beats are lost.
- Stage 1 (cycle N+1): registers per-channel diff = (A^B) & mask and a valid bit.
- Stage 2 (cycle N+2): registers isEqual[c] = (diff_c == 0), bitErr_c = popcount(diff_c), allEqual, and out_valid.
- Latency: exactly 2 cycles from in_valid to out_valid. Full throughput, one beat per cycle, no back-pressure.
- When out_valid=0: isEqual, allEqual and bitErr hold their last values. Accumulators do not change.
- mask = 0: every valid beat reports isEqual all ones, bitErr all zero, no error.
- Accumulator update occurs on the cycle after out_valid, i.e. latency 3 from input:
  - A beat with out_valid=1 and allEqual=0 increments errCnt by 1 and sets sticky.
  - errCnt saturates at 2^CNT_WIDTH-1; it never wraps.
  - On the first such beat (firstErrValid=0), set firstErrValid=1 and firstErrCh = lowest c with isEqual[c]=0.
  - Later mismatches do not alter firstErrCh.
- clr=1: on the next edge, errCnt=0, sticky=0, firstErrValid=0, firstErrCh=0.
  - clr has priority over a simultaneous accumulator update; that beat's mismatch is discarded.
  - Stage 1/2 contents and out_valid are unaffected.
- Arithmetic:
  - bitErr range is 0..DATA_DEPTH and fits in EW bits. DATA_DEPTH=32 gives EW=6.
  - errCnt is unsigned.
- NUM_CH=1: firstErrCh is 1 bit, always 0.

Decomposition:
- Package dec_cmp_pkg:
  - function ew(depth) returning $clog2(depth+1).
  - function chw(n) returning max(1,$clog2(n)).
  - function popcount over a DATA_DEPTH vector (reference model for bench).
- Sub-module dec_popcount:
  - parameter DATA_DEPTH; input vector; output count of ew(DATA_DEPTH) bits.
  - Purely combinational.
  - Instantiated NUM_CH times in stage 2.
- Priority encoder for firstErrCh is inline logic.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and random A/B, then release -> all outputs 0. First out_valid appears exactly 2 cycles after the first post-reset in_valid.
- Equal words (NUM_CH=4, DATA_DEPTH=32): A=B=32'h0 in all channels, mask=all ones -> isEqual=4'b1111, allEqual=1, bitErr all 0, errCnt stays 0.
- Single-bit error: channel 2 has A=32'h0, B=32'h1 -> isEqual=4'b1011, bitErr[ch2]=1. Next cycle: errCnt=1, firstErrValid=1, firstErrCh=2, sticky=1.
- Mask: ch0 A=32'hFFFF_0000, B=32'h0000_0000, mask=32'h0000_FFFF -> isEqual[0]=1. Repeat with mask=32'hFFFF_FFFF -> bitErr[ch0]=16.
- Back-to-back with first-error hold: 5 consecutive mismatch beats, first on ch3 and later on ch0 -> errCnt=5, firstErrCh=3. Then clr coincident with a 6th mismatch -> errCnt=0, sticky=0, firstErrValid=0.
- Saturation: CNT_WIDTH=4, drive 20 mismatch beats -> errCnt reaches 15 and holds. Then assert rst_n=0 mid-stream -> outputs go to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dec_cmp_pkg.sv
// -----------------------------------------------------------------------------
// dec_cmp_pkg
// Shared sizing helpers for the decoder compare checker.
//   ew(depth)      : width able to hold a bit count 0..depth
//   chw(n)         : width of a channel index, at least 1 bit
//   popcount(vec)  : behavioural set-bit count, up to POP_MAX bits
// -----------------------------------------------------------------------------
package dec_cmp_pkg;

    localparam int POP_MAX = 256;

    function automatic int ew(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int popcount(input logic [POP_MAX-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < POP_MAX; i++) begin
            cnt += int'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/dec_popcount.sv
// -----------------------------------------------------------------------------
// dec_popcount
// Purely combinational count of set bits in one channel's masked difference.
// Ports:
//   i_vec   [DATA_DEPTH]      vector to count
//   o_count [ew(DATA_DEPTH)]  number of ones in i_vec (0..DATA_DEPTH)
// -----------------------------------------------------------------------------
module dec_popcount
    import dec_cmp_pkg::*;
#(
    parameter int DATA_DEPTH = 32
) (
    input  logic [DATA_DEPTH-1:0]     i_vec,
    output logic [ew(DATA_DEPTH)-1:0] o_count
);

    localparam int EW = ew(DATA_DEPTH);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        o_count = '0;
        for (int i = 0; i < DATA_DEPTH; i++) begin
            o_count = o_count + EW'(i_vec[i]);
        end
    end

endmodule

// File: rtl/dec_compare_checker.sv
// -----------------------------------------------------------------------------
// dec_compare_checker
// Two-stage pipelined masked comparison of NUM_CH decoded words against
// expected words, with mismatch statistics accumulated one cycle later.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clr            synchronous clear of errCnt/firstErr*/sticky only
//   in_valid,A,B   input beat; channel c at [c*DATA_DEPTH +: DATA_DEPTH]
//   mask           shared compare mask, 1 = bit compared
//   out_valid      results valid (2 cycles after in_valid)
//   isEqual        per-channel masked equality
//   allEqual       AND of isEqual
//   bitErr         per-channel masked differing-bit counts, EW bits each
//   errCnt         saturating count of mismatching beats
//   firstErrValid  first mismatch captured
//   firstErrCh     lowest mismatching channel of the first mismatching beat
//   sticky         any mismatch seen since reset/clr
// -----------------------------------------------------------------------------
module dec_compare_checker
    import dec_cmp_pkg::*;
#(
    parameter int DATA_DEPTH = 32,
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             in_valid,
    input  logic [NUM_CH*DATA_DEPTH-1:0]     A,
    input  logic [NUM_CH*DATA_DEPTH-1:0]     B,
    input  logic [DATA_DEPTH-1:0]            mask,
    output logic                             out_valid,
    output logic [NUM_CH-1:0]                isEqual,
    output logic                             allEqual,
    output logic [NUM_CH*ew(DATA_DEPTH)-1:0] bitErr,
    output logic [CNT_WIDTH-1:0]             errCnt,
    output logic                             firstErrValid,
    output logic [chw(NUM_CH)-1:0]           firstErrCh,
    output logic                             sticky
);

    localparam int EW = ew(DATA_DEPTH);
    localparam int CW = chw(NUM_CH);

    // ---------------- stage 1: masked difference ----------------
    logic [NUM_CH-1:0][DATA_DEPTH-1:0] w_diff;
    logic [NUM_CH-1:0][DATA_DEPTH-1:0] r_s1_diff;
    logic                              r_s1_valid;

    always_comb begin
        w_diff = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_diff[c] = (A[c*DATA_DEPTH +: DATA_DEPTH] ^ B[c*DATA_DEPTH +: DATA_DEPTH]) & mask;
        end
    end

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
        end else begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_diff <= w_diff;
            end
        end
    end

    // ---------------- stage 2: equality and bit counts ----------------
    logic [NUM_CH-1:0][EW-1:0] w_pop;
    logic [NUM_CH-1:0]         w_eq;
    logic [NUM_CH-1:0][EW-1:0] r_bit_err;
    logic [NUM_CH-1:0]         r_is_equal;
    logic                      r_all_equal;
    logic                      r_out_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pop
        dec_popcount #(.DATA_DEPTH(DATA_DEPTH)) u_pop (
            .i_vec   (r_s1_diff[g]),
            .o_count (w_pop[g])
        );
        assign w_eq[g] = (r_s1_diff[g] == '0);
    end

    // Result registers only load on a valid beat so they hold while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_is_equal  <= '0;
            r_all_equal <= 1'b0;
            r_bit_err   <= '0;
        end else begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_is_equal  <= w_eq;
                r_all_equal <= &w_eq;
                r_bit_err   <= w_pop;
            end
        end
    end

    // ---------------- accumulators ----------------
    logic                 w_mismatch;
    logic [CW-1:0]        w_first_ch;
    logic [CNT_WIDTH-1:0] r_err_cnt;
    logic                 r_sticky;
    logic                 r_first_valid;
    logic [CW-1:0]        r_first_ch;

    assign w_mismatch = r_out_valid & ~r_all_equal;

    // Scan from the top down so the lowest failing channel wins.
    always_comb begin
        w_first_ch = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (!r_is_equal[c]) begin
                w_first_ch = CW'(c);
            end
        end
    end

    // clr is checked first so it discards a coincident mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_cnt     <= '0;
            r_sticky      <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
        end else if (clr) begin
            r_err_cnt     <= '0;
            r_sticky      <= 1'b0;
            r_first_valid <= 1'b0;
            r_first_ch    <= '0;
        end else if (w_mismatch) begin
            if (r_err_cnt != '1) begin
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
            end
            r_sticky <= 1'b1;
            if (!r_first_valid) begin
                r_first_valid <= 1'b1;
                r_first_ch    <= w_first_ch;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign isEqual       = r_is_equal;
    assign allEqual      = r_all_equal;
    assign bitErr        = r_bit_err;
    assign errCnt        = r_err_cnt;
    assign sticky        = r_sticky;
    assign firstErrValid = r_first_valid;
    assign firstErrCh    = r_first_ch;

endmodule

// File: tb/tb_dec_compare_checker.sv
// -----------------------------------------------------------------------------
// tb_dec_compare_checker
// Directed scenarios plus randomized beats against a behavioural model.
// A second instance with a 4-bit counter exercises saturation.
// -----------------------------------------------------------------------------
module tb_dec_compare_checker;
    import dec_cmp_pkg::*;

    localparam int DD     = 32;
    localparam int NC     = 4;
    localparam int EW     = ew(DD);
    localparam int CW     = chw(NC);
    localparam int CNTW   = 16;
    localparam int CNTW_S = 4;
    localparam longint MAX_M = (longint'(1) << CNTW) - 1;
    localparam longint MAX_S = (longint'(1) << CNTW_S) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic [NC*DD-1:0] A;
    logic [NC*DD-1:0] B;
    logic [DD-1:0]    mask;

    logic             out_valid,   s_out_valid;
    logic [NC-1:0]    is_equal,    s_is_equal;
    logic             all_equal,   s_all_equal;
    logic [NC*EW-1:0] bit_err,     s_bit_err;
    logic [CNTW-1:0]  err_cnt;
    logic [CNTW_S-1:0] s_err_cnt;
    logic             first_valid, s_first_valid;
    logic [CW-1:0]    first_ch,    s_first_ch;
    logic             sticky,      s_sticky;

    dec_compare_checker #(.DATA_DEPTH(DD), .NUM_CH(NC), .CNT_WIDTH(CNTW)) u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .A(A), .B(B), .mask(mask),
        .out_valid(out_valid), .isEqual(is_equal), .allEqual(all_equal),
        .bitErr(bit_err), .errCnt(err_cnt), .firstErrValid(first_valid),
        .firstErrCh(first_ch), .sticky(sticky)
    );

    dec_compare_checker #(.DATA_DEPTH(DD), .NUM_CH(NC), .CNT_WIDTH(CNTW_S)) u_dut_sat (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
        .A(A), .B(B), .mask(mask),
        .out_valid(s_out_valid), .isEqual(s_is_equal), .allEqual(s_all_equal),
        .bitErr(s_bit_err), .errCnt(s_err_cnt), .firstErrValid(s_first_valid),
        .firstErrCh(s_first_ch), .sticky(s_sticky)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic          m_ov;
    logic [NC-1:0] m_eq;
    int            m_be [NC];
    longint        m_cnt, m_cnt_s;
    logic          m_sticky, m_fv;
    int            m_fch;
    // beat accepted at the last edge, not yet reported
    logic             p_v;
    logic [NC*DD-1:0] p_a, p_b;
    logic [DD-1:0]    p_m;

    task automatic model_reset();
        m_ov = 0; m_eq = '0; m_cnt = 0; m_cnt_s = 0;
        m_sticky = 0; m_fv = 0; m_fch = 0;
        for (int c = 0; c < NC; c++) m_be[c] = 0;
        p_v = 0; p_a = '0; p_b = '0; p_m = '0;
    endtask

    // Advance the model by one clock edge using the inputs now driven.
    task automatic model_edge();
        logic [DD-1:0] d;
        int bad;
        if (clr) begin
            m_cnt = 0; m_cnt_s = 0; m_sticky = 0; m_fv = 0; m_fch = 0;
        end else if (m_ov && (m_eq != {NC{1'b1}})) begin
            if (m_cnt < MAX_M) m_cnt++;
            if (m_cnt_s < MAX_S) m_cnt_s++;
            m_sticky = 1;
            if (!m_fv) begin
                bad = -1;
                for (int c = 0; c < NC; c++) if (bad < 0 && !m_eq[c]) bad = c;
                m_fv = 1;
                m_fch = bad;
            end
        end
        if (p_v) begin
            for (int c = 0; c < NC; c++) begin
                d = (p_a[c*DD +: DD] ^ p_b[c*DD +: DD]) & p_m;
                m_be[c] = $countones(d);
                m_eq[c] = (m_be[c] == 0);
            end
        end
        m_ov = p_v;
        p_v = in_valid; p_a = A; p_b = B; p_m = mask;
    endtask

    task automatic check_all();
        logic [NC*EW-1:0] be;
        logic             all_exp;
        be = '0;
        for (int c = 0; c < NC; c++) be[c*EW +: EW] = EW'(m_be[c]);
        all_exp = (m_eq == {NC{1'b1}});
        check("out_valid",     128'(out_valid),     128'(m_ov));
        check("isEqual",       128'(is_equal),      128'(m_eq));
        check("allEqual",      128'(all_equal),     128'(all_exp));
        check("bitErr",        128'(bit_err),       128'(be));
        check("errCnt",        128'(err_cnt),       128'(m_cnt));
        check("sticky",        128'(sticky),        128'(m_sticky));
        check("firstErrValid", 128'(first_valid),   128'(m_fv));
        check("firstErrCh",    128'(first_ch),      128'(m_fch));
        check("sat.out_valid", 128'(s_out_valid),   128'(m_ov));
        check("sat.isEqual",   128'(s_is_equal),    128'(m_eq));
        check("sat.allEqual",  128'(s_all_equal),   128'(all_exp));
        check("sat.bitErr",    128'(s_bit_err),     128'(be));
        check("sat.errCnt",    128'(s_err_cnt),     128'(m_cnt_s));
        check("sat.sticky",    128'(s_sticky),      128'(m_sticky));
        check("sat.firstErrV", 128'(s_first_valid), 128'(m_fv));
        check("sat.firstErrCh",128'(s_first_ch),    128'(m_fch));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [NC*DD-1:0] a, input logic [NC*DD-1:0] b,
                         input logic [DD-1:0] m, input logic c);
        in_valid = v; A = a; B = b; mask = m; clr = c;
    endtask

    function automatic logic [NC*DD-1:0] chan(input int c, input logic [DD-1:0] w);
        logic [NC*DD-1:0] x;
        x = '0;
        x[c*DD +: DD] = w;
        return x;
    endfunction

    function automatic logic [NC*DD-1:0] rand_words();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    localparam logic [DD-1:0] ONES = '1;
    localparam logic [NC*DD-1:0] ZW = '0;

    initial begin
        logic [NC*DD-1:0] ra, flip;
        logic [DD-1:0]    rm;
        int sel;

        model_reset();
        // Reset held with valid traffic: everything must stay 0.
        rst_n = 1'b0;
        drive(1'b1, rand_words(), rand_words(), ONES, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        // First post-reset beat must appear exactly 2 edges later.
        tick();
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        tick();
        check("latency2", 128'(out_valid), 128'(1));
        repeat (2) tick();
        drive(1'b0, ZW, ZW, ONES, 1'b1);
        tick();

        // Equal words, full mask.
        drive(1'b1, ZW, ZW, ONES, 1'b0);
        repeat (3) tick();
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        repeat (3) tick();
        check("equal.errCnt", 128'(err_cnt), 128'(0));

        // Single-bit error on channel 2.
        drive(1'b1, ZW, chan(2, 32'h1), ONES, 1'b0);
        tick();
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        tick();
        check("ch2.isEqual", 128'(is_equal), 128'(4'b1011));
        tick();
        check("ch2.firstErrCh", 128'(first_ch), 128'(2));

        // Masked-off difference, then the same difference fully compared.
        drive(1'b1, chan(0, 32'hFFFF_0000), ZW, 32'h0000_FFFF, 1'b0);
        tick();
        drive(1'b1, chan(0, 32'hFFFF_0000), ZW, ONES, 1'b0);
        tick();
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        repeat (3) tick();

        // mask = 0 hides any difference.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_words(), rand_words(), '0, 1'b0);
            tick();
        end
        drive(1'b0, ZW, ZW, ONES, 1'b1);
        tick();
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        repeat (3) tick();

        // Five mismatches: first on ch3, then ch0; first channel must stay 3.
        drive(1'b1, ZW, chan(3, 32'h8000_0000), ONES, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ZW, chan(0, 32'h0000_00F0), ONES, 1'b0);
            tick();
        end
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        repeat (3) tick();
        check("b2b.errCnt", 128'(err_cnt), 128'(5));
        check("b2b.firstErrCh", 128'(first_ch), 128'(3));
        // Sixth mismatch, clr asserted while it is at the output.
        drive(1'b1, ZW, chan(1, 32'h1), ONES, 1'b0);
        tick();
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        tick();
        drive(1'b0, ZW, ZW, ONES, 1'b1);
        tick();
        check("clr.errCnt", 128'(err_cnt), 128'(0));
        check("clr.firstErrValid", 128'(first_valid), 128'(0));
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        tick();

        // Saturation of the 4-bit instance.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, rand_words(), ZW, ONES, 1'b0);
            A[DD-1:0] = 32'h1;
            tick();
        end
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        repeat (3) tick();
        check("sat.hold", 128'(s_err_cnt), 128'(15));

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rand_words(), rand_words(), ONES, 1'b0);
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            ra = rand_words();
            flip = '0;
            for (int c = 0; c < NC; c++) begin
                sel = int'($urandom_range(0, 3));
                if (sel == 1) flip[c*DD + int'($urandom_range(0, DD - 1))] = 1'b1;
                else if (sel == 2) flip[c*DD +: DD] = $urandom;
            end
            sel = int'($urandom_range(0, 5));
            rm = (sel == 0) ? '0 : (sel < 3) ? ONES : $urandom;
            drive($urandom_range(0, 3) != 0, ra, ra ^ flip, rm, $urandom_range(0, 19) == 0);
            tick();
        end
        drive(1'b0, ZW, ZW, ONES, 1'b0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
